// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared types and helpers for the floating-point special-case resolver.
//   fp_op_e    : 2-bit op code (ADD, SUB, MUL, DIV)
//   fp_class_t : operand class bits {zero, inf, nan}; all clear means finite
//   cnan()     : canonical NaN (sign 0, exponent and mantissa all ones)
//   inf_val(s) : infinity with sign s
//   zero_val(s): zero with sign s
// The helpers return an FP_MAX_W-bit word built for the requested field widths.
// Callers cast the value down to their own word width.
// -----------------------------------------------------------------------------
package fp_pkg;

   localparam int FP_EXP_W = 8;
   localparam int FP_MAN_W = 23;
   localparam int FP_MAX_W = 64;

   typedef enum logic [1:0] {
      ADD = 2'b00,
      SUB = 2'b01,
      MUL = 2'b10,
      DIV = 2'b11
   } fp_op_e;

   typedef struct packed {
      logic zero;
      logic inf;
      logic nan;
   } fp_class_t;

   function automatic logic [FP_MAX_W-1:0] cnan(input int exp_w = FP_EXP_W,
                                                input int man_w = FP_MAN_W);
      return (64'(1) << (exp_w + man_w)) - 64'(1);
   endfunction

   function automatic logic [FP_MAX_W-1:0] inf_val(input logic s,
                                                   input int exp_w = FP_EXP_W,
                                                   input int man_w = FP_MAN_W);
      logic [FP_MAX_W-1:0] v;
      v = ((64'(1) << exp_w) - 64'(1)) << man_w;
      v[exp_w + man_w] = s;
      return v;
   endfunction

   function automatic logic [FP_MAX_W-1:0] zero_val(input logic s,
                                                    input int exp_w = FP_EXP_W,
                                                    input int man_w = FP_MAN_W);
      logic [FP_MAX_W-1:0] v;
      v = '0;
      v[exp_w + man_w] = s;
      return v;
   endfunction

endpackage

// File: rtl/fp_classify.sv
// -----------------------------------------------------------------------------
// fp_classify
// Combinational IEEE-754 operand classifier.
//   word : input, 1+EXP_W+MAN_W bits, operand to classify
//   cls  : output, fp_class_t {zero, inf, nan}; all clear = finite
//   sign : output, sign bit of the operand
// Macro FP_DENORM_FLUSH_EN: when defined, subnormals (exponent 0, mantissa
// nonzero) classify as zero. Otherwise they classify as finite.
// -----------------------------------------------------------------------------
module fp_classify
   import fp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic [EXP_W+MAN_W:0] word,
   output fp_class_t            cls,
   output logic                 sign
);

   logic [EXP_W-1:0] exp_f;
   logic [MAN_W-1:0] man_f;
   logic             exp_ones;
   logic             exp_zero;
   logic             man_zero;

   assign sign     = word[EXP_W+MAN_W];
   assign exp_f    = word[EXP_W+MAN_W-1:MAN_W];
   assign man_f    = word[MAN_W-1:0];
   assign exp_ones = &exp_f;
   assign exp_zero = ~|exp_f;
   assign man_zero = ~|man_f;

   assign cls.inf = exp_ones &  man_zero;
   assign cls.nan = exp_ones & ~man_zero;
`ifdef FP_DENORM_FLUSH_EN
   assign cls.zero = exp_zero;
`else
   assign cls.zero = exp_zero & man_zero;
`endif

endmodule

// File: rtl/fp_special_resolve_pipe.sv
// -----------------------------------------------------------------------------
// fp_special_resolve_pipe
// Two-stage valid/ready pipeline that resolves IEEE-754 special cases for
// add/sub/mul/div. It replaces the datapath result where a zero, infinity, NaN
// or large-exponent-gap bypass applies.
//   clk, rst         : clock, synchronous active-high reset
//   in_valid/ready   : input handshake for {op, in1, in2, temp_result, toobig}
//   op               : 00 ADD, 01 SUB, 10 MUL, 11 DIV
//   in1, in2         : operands
//   temp_result      : datapath result used when no special case applies
//   toobig           : [0] exponent gap too big (bypass), [1] larger is in2
//   out_valid/ready  : output handshake
//   result           : resolved result
//   flag_invalid     : NaN result from an invalid operation or NaN input
//   flag_divzero     : finite nonzero divided by zero
// Macro FP_DENORM_FLUSH_EN: when defined, subnormal operands count as zero and a
// subnormal temp_result is flushed to a signed zero.
// Latency is 2 cycles. Throughput is 1 bundle per cycle.
// -----------------------------------------------------------------------------
module fp_special_resolve_pipe
   import fp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   localparam int W    = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   op,
   input  logic [W-1:0] in1,
   input  logic [W-1:0] in2,
   input  logic [W-1:0] temp_result,
   input  logic [1:0]   toobig,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result,
   output logic         flag_invalid,
   output logic         flag_divzero
);

   localparam logic [W-1:0] CNAN = W'(cnan(EXP_W, MAN_W));

   // ---------------------------------------------------------------- handshake
   logic s1_valid;
   logic s2_ready;
   logic s1_load;

   // The output stage can take a new bundle when it is empty or being drained.
   assign s2_ready = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_ready;
   assign s1_load  = in_valid && in_ready;

   // ------------------------------------------------------------ S1: classify
   fp_class_t c1_d, c2_d;
   logic      sign1_d, sign2_d;
   logic      s2eff_d;
   logic [W-1:0] in2eff_d;

   fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls1 (
      .word (in1),
      .cls  (c1_d),
      .sign (sign1_d)
   );

   fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls2 (
      .word (in2),
      .cls  (c2_d),
      .sign (sign2_d)
   );

   // SUB is handled as an ADD of the negated second operand from here on.
   assign s2eff_d  = (fp_op_e'(op) == SUB) ? ~sign2_d : sign2_d;
   assign in2eff_d = {s2eff_d, in2[W-2:0]};

   fp_op_e       s1_op;
   logic [1:0]   s1_toobig;
   logic [W-1:0] s1_temp;
   logic [W-1:0] s1_in1;
   logic [W-1:0] s1_in2eff;
   fp_class_t    s1_c1, s1_c2;
   logic         s1_s1, s1_s2eff;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, regardless of the statement order in the block.
      if (rst) begin
         s1_valid <= 1'b0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
      end
   end

   // NOTE: payload registers carry no reset. Only the valid bits gate their use,
   // so clearing them would add reset fan-out without changing behaviour.
   always_ff @(posedge clk) begin
      if (s1_load) begin
         s1_op     <= fp_op_e'(op);
         s1_toobig <= toobig;
         s1_temp   <= temp_result;
         s1_in1    <= in1;
         s1_in2eff <= in2eff_d;
         s1_c1     <= c1_d;
         s1_c2     <= c2_d;
         s1_s1     <= sign1_d;
         s1_s2eff  <= s2eff_d;
      end
   end

   // ------------------------------------------------------------- S2: resolve
   logic [W-1:0] res_d;
   logic         inv_d;
   logic         dz_d;
   logic [W-1:0] temp_sel;
   logic         sx;
   logic         is_addsub;

   assign sx        = s1_s1 ^ s1_s2eff;
   assign is_addsub = (s1_op == ADD) || (s1_op == SUB);

`ifdef FP_DENORM_FLUSH_EN
   assign temp_sel = (~|s1_temp[W-2:MAN_W])
                   ? W'(zero_val(s1_temp[W-1], EXP_W, MAN_W))
                   : s1_temp;
`else
   assign temp_sel = s1_temp;
`endif

   always_comb begin
      // NOTE: every output gets a default first, so no path through the
      // priority chain can leave a value unassigned and infer a latch.
      res_d = temp_sel;
      inv_d = 1'b0;
      dz_d  = 1'b0;

      if (s1_c1.nan || s1_c2.nan) begin
         res_d = CNAN;
         inv_d = 1'b1;
      end else if (is_addsub && s1_toobig[0]) begin
         res_d = s1_toobig[1] ? s1_in2eff : s1_in1;
      end else begin
         unique case (s1_op)
            ADD, SUB: begin
               if (s1_c1.inf && s1_c2.inf) begin
                  if (s1_s1 != s1_s2eff) begin
                     res_d = CNAN;
                     inv_d = 1'b1;
                  end else begin
                     res_d = s1_in1;
                  end
               end else if (s1_c1.inf) begin
                  res_d = s1_in1;
               end else if (s1_c2.inf) begin
                  res_d = s1_in2eff;
               end else if (s1_c1.zero && s1_c2.zero) begin
                  res_d = W'(zero_val(s1_s1 & s1_s2eff, EXP_W, MAN_W));
               end else if (s1_c1.zero) begin
                  res_d = s1_in2eff;
               end else if (s1_c2.zero) begin
                  res_d = s1_in1;
               end
            end
            MUL: begin
               if ((s1_c1.zero && s1_c2.inf) || (s1_c1.inf && s1_c2.zero)) begin
                  res_d = CNAN;
                  inv_d = 1'b1;
               end else if (s1_c1.inf || s1_c2.inf) begin
                  res_d = W'(inf_val(sx, EXP_W, MAN_W));
               end else if (s1_c1.zero || s1_c2.zero) begin
                  res_d = W'(zero_val(sx, EXP_W, MAN_W));
               end
            end
            DIV: begin
               if ((s1_c1.zero && s1_c2.zero) || (s1_c1.inf && s1_c2.inf)) begin
                  res_d = CNAN;
                  inv_d = 1'b1;
               end else if (s1_c2.zero) begin
                  // 0/0 is already handled, so only inf/0 is exempt from divzero.
                  res_d = W'(inf_val(sx, EXP_W, MAN_W));
                  dz_d  = !s1_c1.inf;
               end else if (s1_c1.zero || s1_c2.inf) begin
                  res_d = W'(zero_val(sx, EXP_W, MAN_W));
               end else if (s1_c1.inf) begin
                  res_d = W'(inf_val(sx, EXP_W, MAN_W));
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid    <= 1'b0;
         result       <= '0;
         flag_invalid <= 1'b0;
         flag_divzero <= 1'b0;
      end else if (s2_ready) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            result       <= res_d;
            flag_invalid <= inv_d;
            flag_divzero <= dz_d;
         end
      end
   end

endmodule

// File: tb/tb_fp_special_resolve_pipe.sv
// -----------------------------------------------------------------------------
// tb_fp_special_resolve_pipe
// Directed self-checking bench for fp_special_resolve_pipe at default widths.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fp_special_resolve_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  op;
   logic [31:0] in1, in2, temp_result;
   logic [1:0]  toobig;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        flag_invalid;
   logic        flag_divzero;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fp_special_resolve_pipe dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .op           (op),
      .in1          (in1),
      .in2          (in2),
      .temp_result  (temp_result),
      .toobig       (toobig),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .result       (result),
      .flag_invalid (flag_invalid),
      .flag_divzero (flag_divzero)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // One isolated bundle. It is presented on the cycle after a falling edge and
   // captured at the next rising edge. out_valid must be low one cycle later and
   // high two cycles later.
   task automatic run_vec(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] t, input logic [1:0] tb2,
                          input logic [31:0] exp_res, input logic exp_inv,
                          input logic exp_dz);
      @(negedge clk);
      op = o; in1 = a; in2 = b; temp_result = t; toobig = tb2;
      in_valid = 1'b1; out_ready = 1'b1;
      #1 check({tag, " in_ready"}, 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      check({tag, " early"}, 32'(out_valid), 32'd0);
      @(negedge clk);
      check({tag, " valid"}, 32'(out_valid), 32'd1);
      check({tag, " result"}, result, exp_res);
      check({tag, " invalid"}, 32'(flag_invalid), 32'(exp_inv));
      check({tag, " divzero"}, 32'(flag_divzero), 32'(exp_dz));
   endtask

   logic [31:0] temps [4] = '{32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int  sent;
      int  got;
      bit  saw_block;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      op = 2'b00; in1 = '0; in2 = '0; temp_result = '0; toobig = 2'b00;
      repeat (3) @(negedge clk);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst result", result, 32'h0);
      check("rst invalid", 32'(flag_invalid), 32'd0);
      check("rst divzero", 32'(flag_divzero), 32'd0);
      check("rst in_ready", 32'(in_ready), 32'd1);
      rst = 1'b0;

      // ADD/SUB special cases
      run_vec("add inf-inf", 2'b00, 32'h7F800000, 32'hFF800000, 32'h12345678, 2'b00, 32'h7FFFFFFF, 1, 0);
      run_vec("add inf+inf", 2'b00, 32'hFF800000, 32'hFF800000, 32'h12345678, 2'b00, 32'hFF800000, 0, 0);
      run_vec("sub 1-(-0)", 2'b01, 32'h3F800000, 32'h80000000, 32'h12345678, 2'b00, 32'h3F800000, 0, 0);
      run_vec("sub 0-0", 2'b01, 32'h00000000, 32'h00000000, 32'h12345678, 2'b00, 32'h00000000, 0, 0);
      run_vec("add -0+-0", 2'b00, 32'h80000000, 32'h80000000, 32'h12345678, 2'b00, 32'h80000000, 0, 0);
      run_vec("sub 0-x", 2'b01, 32'h00000000, 32'h40000000, 32'h12345678, 2'b00, 32'hC0000000, 0, 0);
      run_vec("sub x-inf", 2'b01, 32'h3F800000, 32'h7F800000, 32'h12345678, 2'b00, 32'hFF800000, 0, 0);
      run_vec("sub inf-inf", 2'b01, 32'h7F800000, 32'h7F800000, 32'h12345678, 2'b00, 32'h7FFFFFFF, 1, 0);
      run_vec("add plain", 2'b00, 32'h3F800000, 32'h40000000, 32'h40400000, 2'b00, 32'h40400000, 0, 0);
      // bypass and NaN priority
      run_vec("add bypass", 2'b00, 32'h3F800000, 32'h4B000000, 32'h12345678, 2'b11, 32'h4B000000, 0, 0);
      run_vec("sub bypass", 2'b01, 32'h3F800000, 32'h4B000000, 32'h12345678, 2'b11, 32'hCB000000, 0, 0);
      run_vec("add bypass in1", 2'b00, 32'h4B000000, 32'h3F800000, 32'h12345678, 2'b01, 32'h4B000000, 0, 0);
      run_vec("nan bypass", 2'b00, 32'h7FC00000, 32'h3F800000, 32'h12345678, 2'b01, 32'h7FFFFFFF, 1, 0);
      run_vec("mul nan in2", 2'b10, 32'h3F800000, 32'hFF800001, 32'h12345678, 2'b00, 32'h7FFFFFFF, 1, 0);
      // MUL
      run_vec("mul 0*inf", 2'b10, 32'h00000000, 32'hFF800000, 32'h12345678, 2'b00, 32'h7FFFFFFF, 1, 0);
      run_vec("mul -x*inf", 2'b10, 32'hC0000000, 32'h7F800000, 32'h12345678, 2'b00, 32'hFF800000, 0, 0);
      run_vec("mul x*-0", 2'b10, 32'h3F800000, 32'h80000000, 32'h12345678, 2'b00, 32'h80000000, 0, 0);
      // bypass bits ignored outside ADD/SUB
      run_vec("mul toobig", 2'b10, 32'h3F800000, 32'h40000000, 32'h40000000, 2'b11, 32'h40000000, 0, 0);
      // DIV
      run_vec("div x/-0", 2'b11, 32'h40000000, 32'h80000000, 32'h12345678, 2'b00, 32'hFF800000, 0, 1);
      run_vec("div 0/0", 2'b11, 32'h00000000, 32'h00000000, 32'h12345678, 2'b00, 32'h7FFFFFFF, 1, 0);
      run_vec("div x/inf", 2'b11, 32'h3F800000, 32'h7F800000, 32'h12345678, 2'b00, 32'h00000000, 0, 0);
      run_vec("div inf/0", 2'b11, 32'hFF800000, 32'h00000000, 32'h12345678, 2'b00, 32'hFF800000, 0, 0);
      run_vec("div inf/inf", 2'b11, 32'h7F800000, 32'hFF800000, 32'h12345678, 2'b00, 32'h7FFFFFFF, 1, 0);
      run_vec("div 0/-x", 2'b11, 32'h00000000, 32'hC0000000, 32'h12345678, 2'b00, 32'h80000000, 0, 0);
      run_vec("div inf/-x", 2'b11, 32'h7F800000, 32'hC0000000, 32'h12345678, 2'b00, 32'hFF800000, 0, 0);
      // subnormal handling
`ifdef FP_DENORM_FLUSH_EN
      run_vec("mul den*inf", 2'b10, 32'h00000001, 32'h7F800000, 32'h12345678, 2'b00, 32'h7FFFFFFF, 1, 0);
      run_vec("temp flush", 2'b00, 32'h3F800000, 32'h40000000, 32'h80000005, 2'b00, 32'h80000000, 0, 0);
`else
      run_vec("mul den*inf", 2'b10, 32'h00000001, 32'h7F800000, 32'h12345678, 2'b00, 32'h7F800000, 0, 0);
      run_vec("temp flush", 2'b00, 32'h3F800000, 32'h40000000, 32'h80000005, 2'b00, 32'h80000005, 0, 0);
`endif

      // Stream of 4 MUL bundles with a 3-cycle downstream stall.
      sent = 0; got = 0; saw_block = 0;
      for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
         @(negedge clk);
         out_ready = !(cyc >= 2 && cyc < 5);
         if (sent < 4) begin
            in_valid = 1'b1; op = 2'b10; toobig = 2'b00;
            in1 = 32'h3F800000; in2 = 32'h40400000; temp_result = temps[sent];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (in_valid && !in_ready) saw_block = 1;
         if (out_valid && out_ready) begin
            check($sformatf("stream result %0d", got), result, temps[got]);
            check($sformatf("stream invalid %0d", got), 32'(flag_invalid), 32'd0);
            got++;
         end
         if (in_valid && in_ready) sent++;
      end
      in_valid = 1'b0;
      check("stream count", 32'(got), 32'd4);
      check("stream backpressure", 32'(saw_block), 32'd1);
      @(negedge clk);
      check("stream no dup", 32'(out_valid), 32'd0);

      // Reset with two bundles in flight.
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         in_valid = 1'b1; op = 2'b10; toobig = 2'b00;
         in1 = 32'h3F800000; in2 = 32'h40400000; temp_result = temps[i];
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("pre-rst out_valid", 32'(out_valid), 32'd1);
      check("pre-rst in_ready", 32'(in_ready), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid-rst out_valid", 32'(out_valid), 32'd0);
      check("mid-rst result", result, 32'h0);
      check("mid-rst in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("post-rst drained", 32'(out_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
